// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RV32 pipeline.
// It keeps a shadow copy of the ID/EX, EX/MEM and MEM/WB control fields.
// From those it drives the forwarding selects, load-use stalls, branch flushes
// and the post-reset warm-up.
module pipeline_hazard_ctrl #(
  parameter int unsigned WARMUP_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    StWarmup,
    StRun,
    StLoadStall,
    StBrFlush
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } stage_t;

  state_e      state_q, state_d;
  logic [31:0] warm_q, warm_d;
  stage_t      id_ex_q, id_ex_d, ex_mem_q, mem_wb_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic        load_use;
  logic        stall_inc, flush_inc;

  // Downstream stages keep the full field set for debug visibility only.
  logic unused_fields;
  assign unused_fields = ^{ex_mem_q.rs1, ex_mem_q.rs2, ex_mem_q.uses_rs2, ex_mem_q.mem_read,
                           mem_wb_q.rs1, mem_wb_q.rs2, mem_wb_q.uses_rs2, mem_wb_q.mem_read};

  // Load in ID/EX whose destination the instruction in ID wants to read.
  assign load_use = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != 5'd0) && id_valid &&
                    ((id_ex_q.rd == id_rs1) || (id_uses_rs2 && (id_ex_q.rd == id_rs2)));

  // Next-state logic and pipeline control outputs.
  always_comb begin
    state_d      = state_q;
    warm_d       = warm_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    case (state_q)
      StWarmup: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        warm_d       = (warm_q == 32'd0) ? 32'd0 : warm_q - 32'd1;
        if (warm_q <= 32'd1) state_d = StRun;
      end
      StRun, StLoadStall: begin
        state_d = StRun;
        if (ex_branch_taken) begin
          // A branch outranks a load-use stall: the stalled instruction is squashed anyway.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_inc    = 1'b1;
          state_d      = StBrFlush;
        end else if ((state_q == StRun) && load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          stall_inc    = 1'b1;
          state_d      = StLoadStall;
        end
      end
      StBrFlush: begin
        // Squash the fetch issued during the branch cycle, which arrives one cycle late.
        if_id_flush = 1'b1;
        flush_inc   = 1'b1;
        state_d     = StRun;
      end
      default: state_d = StWarmup;
    endcase
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
    end
  end

  // Fields entering the ID/EX shadow stage; control bits cleared for bubbles.
  always_comb begin
    id_ex_d           = '0;
    id_ex_d.valid     = id_valid && !id_ex_bubble;
    id_ex_d.rs1       = id_rs1;
    id_ex_d.rs2       = id_rs2;
    id_ex_d.uses_rs2  = id_uses_rs2;
    id_ex_d.rd        = id_rd;
    id_ex_d.reg_write = id_reg_write && id_ex_d.valid;
    id_ex_d.mem_read  = id_mem_read && id_ex_d.valid;
  end

  // Forwarding selects for the instruction in ID/EX; EX/MEM beats MEM/WB.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (!reset && id_ex_q.valid) begin
      if (ex_mem_q.reg_write && (ex_mem_q.rd != 5'd0) && (ex_mem_q.rd == id_ex_q.rs1)) begin
        forward_a = 2'b10;
      end else if (mem_wb_q.reg_write && (mem_wb_q.rd != 5'd0) &&
                   (mem_wb_q.rd == id_ex_q.rs1)) begin
        forward_a = 2'b01;
      end
      if (id_ex_q.uses_rs2) begin
        if (ex_mem_q.reg_write && (ex_mem_q.rd != 5'd0) && (ex_mem_q.rd == id_ex_q.rs2)) begin
          forward_b = 2'b10;
        end else if (mem_wb_q.reg_write && (mem_wb_q.rd != 5'd0) &&
                     (mem_wb_q.rd == id_ex_q.rs2)) begin
          forward_b = 2'b01;
        end
      end
    end
  end

  // FSM state and warm-up counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (WARMUP_CYCLES == 0) ? StRun : StWarmup;
      warm_q  <= WARMUP_CYCLES;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  // Shadow pipeline advances every non-reset cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= id_ex_q;
      mem_wb_q <= ex_mem_q;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = reset ? '0 : stall_q;
  assign flush_cnt = reset ? '0 : flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a driver applies one directed vector per
// cycle and queues the expected response; a monitor checks it on the falling edge.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  typedef struct {
    string         name;
    logic [7:0]    ctl;
    logic [CW-1:0] st;
    logic [CW-1:0] fc;
  } exp_t;

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
  localparam logic [3:0] N = 4'b1100;
  localparam logic [3:0] S = 4'b0001;
  localparam logic [3:0] B = 4'b1111;
  localparam logic [3:0] F = 4'b1110;
  localparam logic [3:0] R = 4'b0011;
  localparam logic [3:0] W = 4'b1111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic id_valid = 1'b0, id_uses_rs2 = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic ex_branch_taken = 1'b0;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [1:0] forward_a, forward_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.WARMUP_CYCLES(1), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs2    (id_uses_rs2),
    .id_rd          (id_rd),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .forward_a      (forward_a),
    .forward_b      (forward_b),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  function automatic instr_t mk(input logic v, input int rs1, input int rs2, input logic u2,
                                input int rd, input logic rw, input logic mr);
    instr_t i;
    i.v   = v;
    i.rs1 = rs1[4:0];
    i.rs2 = rs2[4:0];
    i.u2  = u2;
    i.rd  = rd[4:0];
    i.rw  = rw;
    i.mr  = mr;
    return i;
  endfunction

  // One cycle: drive inputs just after the rising edge and queue the expected outputs.
  task automatic step(input string nm, input logic rst, input logic br, input instr_t ins,
                      input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                      input int st, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    ex_branch_taken = br;
    id_valid        = ins.v;
    id_rs1          = ins.rs1;
    id_rs2          = ins.rs2;
    id_uses_rs2     = ins.u2;
    id_rd           = ins.rd;
    id_reg_write    = ins.rw;
    id_mem_read     = ins.mr;
    e.name = nm;
    e.ctl  = {ctl, fa, fb};
    e.st   = st[CW-1:0];
    e.fc   = fc[CW-1:0];
    sb.push_back(e);
  endtask

  // Monitor: the controller presents a response every cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = sb.pop_front();
      act = {pc_write, if_id_write, if_id_flush, id_ex_bubble, forward_a, forward_b};
      n_cmp++;
      if (act !== e.ctl) begin
        n_err++;
        $display("FAIL %s ctl {pc,ifw,flush,bubble,fa,fb}: got %b want %b", e.name, act, e.ctl);
      end
      n_cmp++;
      if (stall_cnt !== e.st) begin
        n_err++;
        $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.st);
      end
      n_cmp++;
      if (flush_cnt !== e.fc) begin
        n_err++;
        $display("FAIL %s flush_cnt: got %0d want %0d", e.name, flush_cnt, e.fc);
      end
    end
  end

  initial begin
    instr_t nop, i1, i2, i3, i4, i5, i6, i7, i8, lw, a1, a2, x1, dl;
    nop = mk(0, 0, 0, 0, 0, 0, 0);
    i1  = mk(1, 0, 0, 0, 3, 1, 0);  // addi x3,x0,17
    i2  = mk(1, 3, 0, 0, 4, 1, 0);  // addi x4,x3,3
    i3  = mk(1, 3, 0, 0, 5, 1, 0);  // addi x5,x3,15
    i4  = mk(1, 0, 0, 0, 3, 1, 0);  // addi x3,x0,9
    i5  = mk(1, 3, 0, 0, 5, 1, 0);  // addi x5,x3,15
    i6  = mk(1, 3, 5, 1, 6, 1, 0);  // add  x6,x3,x5
    i7  = mk(1, 0, 0, 0, 0, 1, 0);  // addi x0,x0,5
    i8  = mk(1, 0, 0, 1, 7, 1, 0);  // add  x7,x0,x0
    lw  = mk(1, 0, 0, 0, 2, 1, 1);  // lw   x2,20(x0)
    a1  = mk(1, 2, 2, 1, 4, 1, 0);  // add  x4,x2,x2
    a2  = mk(1, 3, 2, 0, 4, 1, 0);  // addi x4,x3,1 (rs2 field unused)
    x1  = mk(1, 0, 0, 0, 9, 1, 0);  // addi x9,x0,1
    dl  = mk(1, 2, 0, 0, 2, 1, 1);  // lw   x2,0(x2)

    step("reset_1", 1, 0, nop, R, 2'b00, 2'b00, 0, 0);
    step("reset_2", 1, 0, nop, R, 2'b00, 2'b00, 0, 0);
    step("reset_3", 1, 0, nop, R, 2'b00, 2'b00, 0, 0);
    step("warmup", 0, 0, nop, W, 2'b00, 2'b00, 0, 0);
    step("run_i1", 0, 0, i1, N, 2'b00, 2'b00, 0, 0);
    step("run_i2", 0, 0, i2, N, 2'b00, 2'b00, 0, 0);
    step("fwd_a_exmem", 0, 0, i3, N, 2'b10, 2'b00, 0, 0);
    step("fwd_a_memwb", 0, 0, i4, N, 2'b01, 2'b00, 0, 0);
    step("run_i5", 0, 0, i5, N, 2'b00, 2'b00, 0, 0);
    step("fwd_a_exmem_2", 0, 0, i6, N, 2'b10, 2'b00, 0, 0);
    step("fwd_a01_b10", 0, 0, i7, N, 2'b01, 2'b10, 0, 0);
    step("x0_writer", 0, 0, i8, N, 2'b00, 2'b00, 0, 0);
    step("x0_no_forward", 0, 0, nop, N, 2'b00, 2'b00, 0, 0);
    step("lw_issue", 0, 0, lw, N, 2'b00, 2'b00, 0, 0);
    step("load_use_stall", 0, 0, a1, S, 2'b00, 2'b00, 0, 0);
    step("load_stall_adv", 0, 0, a1, N, 2'b00, 2'b00, 1, 0);
    step("fwd_load_memwb", 0, 0, lw, N, 2'b01, 2'b01, 1, 0);
    step("no_dep_no_stall", 0, 0, a2, N, 2'b00, 2'b00, 1, 0);
    step("no_dep_after", 0, 0, nop, N, 2'b00, 2'b00, 1, 0);
    step("branch", 0, 1, x1, B, 2'b00, 2'b00, 1, 0);
    step("br_flush", 0, 0, nop, F, 2'b00, 2'b00, 1, 1);
    step("after_flush", 0, 0, nop, N, 2'b00, 2'b00, 1, 2);
    step("lw_issue_2", 0, 0, lw, N, 2'b00, 2'b00, 1, 2);
    step("branch_beats_stall", 0, 1, a1, B, 2'b00, 2'b00, 1, 2);
    step("br_flush_2", 0, 0, nop, F, 2'b00, 2'b00, 1, 3);
    step("after_flush_2", 0, 0, nop, N, 2'b00, 2'b00, 1, 4);
    step("lw_issue_3", 0, 0, lw, N, 2'b00, 2'b00, 1, 4);
    step("stall_3", 0, 0, a1, S, 2'b00, 2'b00, 1, 4);
    step("reset_in_stall", 1, 0, a1, R, 2'b00, 2'b00, 0, 0);
    step("warmup_again", 0, 0, a1, W, 2'b00, 2'b00, 0, 0);
    step("run_again", 0, 0, nop, N, 2'b00, 2'b00, 0, 0);

    // Chain of dependent loads: a stall every other cycle until the counter saturates.
    step("sat_lw", 0, 0, lw, N, 2'b00, 2'b00, 0, 0);
    for (int j = 0; j < 17; j++) begin
      step("sat_stall", 0, 0, dl, S, (j == 0) ? 2'b00 : 2'b01, 2'b00, (j < 15) ? j : 15, 0);
      step("sat_adv", 0, 0, dl, N, 2'b00, 2'b00, (j + 1 < 15) ? j + 1 : 15, 0);
    end
    step("sat_hold", 0, 0, nop, N, 2'b01, 2'b00, 15, 0);
    step("sat_end", 0, 0, nop, N, 2'b00, 2'b00, 15, 0);

    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Keeps its own shadow copy of the destination/control fields in ID/EX, EX/MEM and MEM/WB.
- From those it drives the forward_a/forward_b mux selects, load-use stalls, taken-branch flushes and the post-reset warm-up.
- Sits beside the datapath; the pipeline registers take its write-enable, bubble and flush outputs.

Parameters:
- WARMUP_CYCLES, 1, cycles after reset release during which IF/ID is flushed; covers the registered instruction-memory read.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_uses_rs2  in  1  ID instruction reads rs2 (R-type, store, branch)
- id_rd  in  5  ID destination register
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- pc_write  out  1  PC enable (PCWrite)
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  zero IF/ID contents (insert NOP)
- id_ex_bubble  out  1  zero ID/EX control fields
- forward_a  out  2  ALU input A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- forward_b  out  2  ALU input B select, same encoding
- stall_cnt  out  CNT_W  load-use stall cycles since reset, saturating
- flush_cnt  out  CNT_W  branch flush cycles since reset, saturating

Behaviour:
- Applies in the cycle reset is high and after it:
  - State goes to WARMUP; warm-up counter loads WARMUP_CYCLES.
  - All shadow stages are invalid, with reg_write = 0 and mem_read = 0.
  - Counters are 0.
  - Outputs: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, forward_a=forward_b=00.
- Shadow pipeline, advancing every non-reset cycle:
  - ID/EX takes the ID fields, or is invalid if id_ex_bubble=1 or id_valid=0.
  - EX/MEM takes ID/EX; MEM/WB takes EX/MEM.
  - Fields kept per stage: rs1, rs2, uses_rs2 (ID/EX only), rd, reg_write, mem_read, valid.
- Forwarding is combinational from the shadow registers and applies to the instruction in ID/EX:
  - forward_a=10 if EX/MEM.reg_write and EX/MEM.rd!=0 and EX/MEM.rd==ID/EX.rs1.
  - Otherwise 01 if the same condition holds for MEM/WB.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB.
  - forward_b uses the same rules on rs2, and is forced to 00 when ID/EX.uses_rs2=0.
  - An invalid ID/EX entry gives 00 on both.
- FSM states: WARMUP, RUN, LOAD_STALL, BR_FLUSH.
- WARMUP:
  - Outputs: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1.
  - The counter decrements each cycle; move to RUN when it reaches 0. WARMUP_CYCLES=0 goes straight to RUN.
- RUN, checked in this priority order:
  - Taken branch (ex_branch_taken=1): if_id_flush=1, id_ex_bubble=1, pc_write=1 so the branch target loads; next state BR_FLUSH.
  - Load-use: ID/EX.valid, ID/EX.mem_read, ID/EX.rd!=0, id_valid, and (ID/EX.rd==id_rs1, or id_uses_rs2 and ID/EX.rd==id_rs2). Response: pc_write=0, if_id_write=0, id_ex_bubble=1; next state LOAD_STALL.
  - Otherwise: pc_write=1, if_id_write=1, no flush or bubble.
- LOAD_STALL:
  - Exactly one cycle of normal advance; the load is now in MEM/WB and is forwarded with 01.
  - Back to RUN.
  - A taken branch in this cycle is handled exactly as in RUN and moves to BR_FLUSH.
  - A load-use hazard is not re-detected in this cycle.
- BR_FLUSH:
  - Second squash slot, needed because the fetch issued in the branch cycle returns one cycle late.
  - Outputs: if_id_flush=1, pc_write=1, if_id_write=1, id_ex_bubble=0; back to RUN.
  - ex_branch_taken is ignored here, since EX holds a bubble.
- Branch and load-use in the same cycle: the branch wins, the stall is dropped and stall_cnt does not increment.
- Counters:
  - stall_cnt increments in each cycle the load-use stall is asserted.
  - flush_cnt increments in the branch cycle and in the BR_FLUSH cycle.
  - Both saturate at all-ones.
- Reset asserted mid-stall or mid-flush: immediate return to the reset values; no partial stall or flush survives.
- Latency: hazard outputs are combinational from the state and shadow registers plus the current ID/EX inputs. There is no added pipeline delay.

Test Plan:
- Reset held 3 cycles, then released with WARMUP_CYCLES=1: pc_write=0 and if_id_flush=1 during reset; exactly 1 WARMUP cycle with flush=1; then RUN with pc_write=1; both counters 0.
- addi x3,x0,17 then addi x4,x3,3: forward_a=10 when the second addi is in EX. Add addi x5,x3,15 one slot later: forward_a=01. add x6,x3,x5 directly after addi x5,...: forward_b=10, forward_a=01.
- rd=x0 writer (addi x0,x0,5) followed by add x7,x0,x0: forward_a=forward_b=00.
- lw x2,20(x0) then add x4,x2,x2:
  - One cycle of pc_write=0, if_id_write=0, id_ex_bubble=1, then stall_cnt=1.
  - The add then executes with forward_a=forward_b=01.
  - lw x2 followed by addi x4,x3,1 (no dependency): no stall.
- ex_branch_taken pulsed for 1 cycle: if_id_flush=1 for 2 consecutive cycles and id_ex_bubble=1 in the first; flush_cnt=2. Same cycle as a load-use hazard: no stall, stall_cnt unchanged.
- Reset asserted in the LOAD_STALL cycle: the next cycle shows reset outputs and WARMUP restarts. Force stall_cnt to saturate at 0xFFFF; further stalls leave it at 0xFFFF.
